// File: rtl/aes_round_ctrl.sv
// Round sequencer for the AES-128 CED datapath: steps KX/SB/SR/MC, gates state writes on check match.
// Optional macro CED_RETRY_EN adds a one-shot re-compare per stage occurrence and the retry_cnt output.
`timescale 1ns/1ps
module aes_round_ctrl #(
   parameter int NR = 10,
   parameter int DW = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] stage_out,
   input  logic [DW-1:0] stage_chk,
   output logic          busy,
   output logic          done,
   output logic          fault,
   output logic [3:0]    round,
   output logic [1:0]    stage,
   output logic          st_load,
   output logic          st_we,
   output logic          key_step,
   output logic [7:0]    rcon,
   output logic [3:0]    fault_round,
   output logic [1:0]    fault_stage
`ifdef CED_RETRY_EN
   ,
   output logic [7:0]    retry_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_SB, S_SR, S_MC, S_KX, S_DONE
   } state_t;

   localparam logic [3:0] LP_NR = 4'(NR);
   localparam logic [1:0] STG_KX = 2'd0, STG_SB = 2'd1, STG_SR = 2'd2, STG_MC = 2'd3;

   state_t r_state;
   logic   w_active;
   logic   w_match;
   logic   w_retry;
   logic   w_fault;

   assign w_active = (r_state == S_INIT) || (r_state == S_SB) || (r_state == S_SR) ||
                     (r_state == S_MC)   || (r_state == S_KX);
   assign w_match  = (stage_out == stage_chk);

   // NOTE: st_we and key_step must follow this cycle's compare, so they stay combinational.
   assign st_we    = w_active && w_match;
   assign key_step = (r_state == S_KX) && w_match;

`ifdef CED_RETRY_EN
   logic r_retry_used;
   assign w_retry = w_active && !w_match && !r_retry_used;
`else
   assign w_retry = 1'b0;
`endif
   assign w_fault = w_active && !w_match && !w_retry;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         fault       <= 1'b0;
         round       <= 4'd0;
         stage       <= STG_KX;
         st_load     <= 1'b0;
         rcon        <= 8'h01;
         fault_round <= 4'd0;
         fault_stage <= 2'd0;
`ifdef CED_RETRY_EN
         r_retry_used <= 1'b0;
         retry_cnt    <= 8'd0;
`endif
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state     <= S_INIT;
                  busy        <= 1'b1;
                  stage       <= STG_KX;
                  st_load     <= 1'b1;
                  round       <= 4'd0;
                  rcon        <= 8'h01;
                  fault       <= 1'b0;
                  fault_round <= 4'd0;
                  fault_stage <= 2'd0;
`ifdef CED_RETRY_EN
                  r_retry_used <= 1'b0;
                  retry_cnt    <= 8'd0;
`endif
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: begin
               if (w_fault) begin
                  r_state <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  st_load <= 1'b0;
                  fault   <= 1'b1;
                  if (!fault) begin
                     fault_round <= round;
                     fault_stage <= stage;
                  end
               end else if (w_retry) begin
                  // Hold the stage for one re-compare; round, rcon and stage are left untouched.
`ifdef CED_RETRY_EN
                  r_retry_used <= 1'b1;
                  if (retry_cnt != 8'hff) retry_cnt <= retry_cnt + 8'd1;
`endif
               end else begin
`ifdef CED_RETRY_EN
                  r_retry_used <= 1'b0;
`endif
                  st_load <= 1'b0;
                  case (r_state)
                     S_INIT: begin r_state <= S_SB; round <= 4'd1; stage <= STG_SB; end
                     S_SB:   begin r_state <= S_SR; stage <= STG_SR; end
                     S_SR: begin
                        if (round < LP_NR) begin r_state <= S_MC; stage <= STG_MC; end
                        else               begin r_state <= S_KX; stage <= STG_KX; end
                     end
                     S_MC:   begin r_state <= S_KX; stage <= STG_KX; end
                     default: begin
                        if (round < LP_NR) begin
                           r_state <= S_SB;
                           stage   <= STG_SB;
                           round   <= round + 4'd1;
                           rcon    <= xtime(rcon);
                        end else begin
                           r_state <= S_DONE;
                           busy    <= 1'b0;
                           done    <= 1'b1;
                        end
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: clean run, rcon sequence, CED faults, mid-run reset, held start.
`timescale 1ns/1ps
module tb_aes_round_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] stage_out;
   logic [127:0] stage_chk;
   logic         busy, done, fault, st_load, st_we, key_step;
   logic [3:0]   round, fault_round;
   logic [1:0]   stage, fault_stage;
   logic [7:0]   rcon;
`ifdef CED_RETRY_EN
   logic [7:0]   retry_cnt;
`endif

   aes_round_ctrl #(.NR(10), .DW(128)) dut (
      .clk(clk), .rst(rst), .start(start),
      .stage_out(stage_out), .stage_chk(stage_chk),
      .busy(busy), .done(done), .fault(fault),
      .round(round), .stage(stage), .st_load(st_load),
      .st_we(st_we), .key_step(key_step), .rcon(rcon),
      .fault_round(fault_round), .fault_stage(fault_stage)
`ifdef CED_RETRY_EN
      , .retry_cnt(retry_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Per-operation statistics gathered by run_op.
   int         done_cyc, busy_cnt, we_cnt, ks_cnt;
   logic       we_at_lo, round_bad, mc_in_last;
   logic [7:0] rcon_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".busy"},        32'(busy),        32'd0);
      check({tag, ".done"},        32'(done),        32'd0);
      check({tag, ".fault"},       32'(fault),       32'd0);
      check({tag, ".st_load"},     32'(st_load),     32'd0);
      check({tag, ".st_we"},       32'(st_we),       32'd0);
      check({tag, ".key_step"},    32'(key_step),    32'd0);
      check({tag, ".round"},       32'(round),       32'd0);
      check({tag, ".stage"},       32'(stage),       32'd0);
      check({tag, ".rcon"},        32'(rcon),        32'h01);
      check({tag, ".fault_round"}, 32'(fault_round), 32'd0);
      check({tag, ".fault_stage"}, 32'(fault_stage), 32'd0);
   endtask

   // Starts an operation from IDLE (called at posedge+1). Cycle k=1 is the cycle after the
   // accept edge. Check bit 0 is flipped during cycles lo..hi. rst is pulsed in cycle rst_at.
   // Returns at mid-cycle of the done cycle (or the reset cycle).
   task automatic run_op(input int lo, input int hi, input bit hold, input int rst_at);
      logic [127:0] data;
      logic [3:0]   prev_round;
      start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      done_cyc = 0; busy_cnt = 0; we_cnt = 0; ks_cnt = 0;
      we_at_lo = 1'bx; round_bad = 1'b0; mc_in_last = 1'b0;
      rcon_q.delete();
      prev_round = 4'd0;
      for (int k = 1; k <= 60; k++) begin
         data      = {$urandom, $urandom, $urandom, $urandom};
         stage_out = data;
         stage_chk = (k >= lo && k <= hi) ? (data ^ 128'h1) : data;
         #2;
         if (k == rst_at) begin
            rst = 1'b1;
            #1;
            check_reset_outputs("rst_mid");
            rst = 1'b0;
            done_cyc = k;
            break;
         end
         #2;
         if (k == 1) begin
            check("init.round",   32'(round),   32'd0);
            check("init.stage",   32'(stage),   32'd0);
            check("init.st_load", 32'(st_load), 32'd1);
         end
         if (k == lo) we_at_lo = st_we;
         if (busy) busy_cnt++;
         if (st_we) we_cnt++;
         if (key_step) begin
            ks_cnt++;
            rcon_q.push_back(rcon);
         end
         if (round != prev_round && round != prev_round + 4'd1) round_bad = 1'b1;
         prev_round = round;
         if (round == 4'd10 && stage == 2'd3) mc_in_last = 1'b1;
         if (done) begin
            done_cyc = k;
            break;
         end
         @(posedge clk); #1;
      end
      if (done_cyc == 0) check("op_timeout", 32'd0, 32'd1);
   endtask

   task automatic next_cycle();
      stage_out = '0;
      stage_chk = '0;
      @(posedge clk); #1;
   endtask

   logic [7:0] rcon_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   initial begin
      rst = 1'b1; start = 1'b0; stage_out = '0; stage_chk = '0;
      #1;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      next_cycle();

      // Clean run with rcon sequence.
      run_op(0, -1, 1'b0, 0);
      check("clean.done_cyc", 32'(done_cyc), 32'd41);
      check("clean.busy_cnt", 32'(busy_cnt), 32'd40);
      check("clean.we_cnt",   32'(we_cnt),   32'd40);
      check("clean.ks_cnt",   32'(ks_cnt),   32'd10);
      check("clean.fault",    32'(fault),    32'd0);
      check("clean.round",    32'(round),    32'd10);
      check("clean.round_seq",32'(round_bad),32'd0);
      check("clean.no_mc10",  32'(mc_in_last), 32'd0);
      check("rcon.count",     32'(rcon_q.size()), 32'd10);
      for (int i = 0; i < 10 && i < rcon_q.size(); i++)
         check($sformatf("rcon[%0d]", i + 1), 32'(rcon_q[i]), 32'(rcon_exp[i]));
      next_cycle();
      check("clean.idle_done", 32'(done), 32'd0);

`ifndef CED_RETRY_EN
      // Round 3 MC is cycle 12: 1 INIT + 2*4 rounds + SB, SR, MC.
      run_op(12, 12, 1'b0, 0);
      check("f3mc.we_at_flip",  32'(we_at_lo),    32'd0);
      check("f3mc.done_cyc",    32'(done_cyc),    32'd13);
      check("f3mc.we_cnt",      32'(we_cnt),      32'd11);
      check("f3mc.fault",       32'(fault),       32'd1);
      check("f3mc.fault_round", 32'(fault_round), 32'd3);
      check("f3mc.fault_stage", 32'(fault_stage), 32'd3);
      next_cycle();
      check("f3mc.sticky",      32'(fault),       32'd1);
      check("f3mc.busy_idle",   32'(busy),        32'd0);
`else
      // Round 5 SB is cycle 18; a single flip costs one retry cycle.
      run_op(18, 18, 1'b0, 0);
      check("r5sb1.we_at_flip", 32'(we_at_lo),  32'd0);
      check("r5sb1.done_cyc",   32'(done_cyc),  32'd42);
      check("r5sb1.we_cnt",     32'(we_cnt),    32'd40);
      check("r5sb1.fault",      32'(fault),     32'd0);
      check("r5sb1.retry_cnt",  32'(retry_cnt), 32'd1);
      next_cycle();
      run_op(18, 19, 1'b0, 0);
      check("r5sb2.done_cyc",    32'(done_cyc),    32'd20);
      check("r5sb2.fault",       32'(fault),       32'd1);
      check("r5sb2.fault_round", 32'(fault_round), 32'd5);
      check("r5sb2.fault_stage", 32'(fault_stage), 32'd1);
      next_cycle();
      check("r5sb2.sticky",      32'(fault),       32'd1);
`endif

      // Reset at round 6 SR (cycle 23), then a clean run clears the sticky fault.
      run_op(0, -1, 1'b0, 23);
      next_cycle();
      run_op(0, -1, 1'b0, 0);
      check("post_rst.done_cyc", 32'(done_cyc), 32'd41);
      check("post_rst.fault",    32'(fault),    32'd0);
      check("post_rst.we_cnt",   32'(we_cnt),   32'd40);
      next_cycle();

      // start held high: ignored while busy and in DONE, re-accepted from IDLE.
      run_op(0, -1, 1'b1, 0);
      check("hold.done_cyc", 32'(done_cyc), 32'd41);
      check("hold.we_cnt",   32'(we_cnt),   32'd40);
      next_cycle();
      check("hold.idle_busy", 32'(busy), 32'd0);
      check("hold.idle_done", 32'(done), 32'd0);
      next_cycle();
      check("hold.restart_busy",  32'(busy),    32'd1);
      check("hold.restart_load",  32'(st_load), 32'd1);
      check("hold.restart_round", 32'(round),   32'd0);
      start = 1'b0;
      begin
         int n;
         n = 0;
         while (!done && n < 60) begin
            next_cycle();
            n++;
         end
         check("hold.second_done", 32'(done), 32'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequencing controller for the AES-128 CED round datapath.
- Steps the shared state register through the stages in order: initial key XOR, then SubBytes, ShiftRows, MixColumns and key XOR for each round. MixColumns is skipped in the final round.
- Each cycle it compares the flattened 128-bit actual stage result against the flattened predicted/check result.
- It gates state writes on a match, reports faults, and drives the key-schedule step and rcon.

Parameters:
- NR, 10, number of rounds; legal values 10/12/14.
- DW, 128, width of the flattened state and check vectors.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin an encryption; accepted only in IDLE.
- stage_out  in  DW  flattened actual result of the currently selected stage.
- stage_chk  in  DW  flattened CED-predicted result of the currently selected stage.
- busy  out  1  high from the cycle after start is accepted until DONE is entered.
- done  out  1  one-cycle completion pulse.
- fault  out  1  sticky CED mismatch flag.
- round  out  4  current round number; 0 = initial key XOR.
- stage  out  2  stage select: 0 = KX, 1 = SB, 2 = SR, 3 = MC.
- st_load  out  1  state register takes the plaintext XOR key path (INIT cycle only).
- st_we  out  1  state register write enable.
- key_step  out  1  advance the key schedule to the next round key.
- rcon  out  8  round constant for the key schedule.
- fault_round  out  4  round in which the first fault occurred.
- fault_stage  out  2  stage in which the first fault occurred.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state = IDLE.
  - busy, done, fault, st_load, st_we, key_step = 0.
  - round = 0, stage = 0, rcon = 8'h01, fault_round = 0, fault_stage = 0.
- States: IDLE, INIT, SB, SR, MC, KX, DONE. Each state except IDLE and DONE lasts exactly 1 cycle unless a CED retry occurs.
- IDLE:
  - start=1 moves to INIT.
  - On acceptance: fault, fault_round and fault_stage clear; round = 0; rcon = 8'h01.
- INIT:
  - stage = 0, st_load = 1.
  - Compares stage_out against stage_chk.
  - Next state is SB with round = 1.
- SB -> SR.
- SR -> MC when round < NR; SR -> KX when round = NR.
- MC -> KX.
- KX:
  - key_step = 1.
  - If round < NR: round increments, rcon updates to xtime(rcon) (shift left 1; XOR 8'h1b if the old MSB was 1), next state SB.
  - If round = NR: next state DONE.
- DONE: done = 1 for one cycle, then IDLE.
- Compare rule (every INIT/SB/SR/MC/KX cycle): match = (stage_out == stage_chk), full DW-bit equality.
  - st_we = match in that cycle.
  - On a mismatch, the state register is not written.
- Mismatch without retry:
  - fault is set on the next edge.
  - fault_round and fault_stage capture the failing round and stage; they capture the first failure only.
  - FSM goes straight to DONE: done pulses with fault = 1 and no further st_we.
- Latency (NR=10, no faults):
  - 1 INIT + 9×4 + 3 = 40 stage cycles.
  - done is high in the 41st cycle after the start-accept edge.
  - st_we is asserted in 40 cycles; key_step in 10 cycles.
- start while busy or in DONE is ignored.
- fault remains set through IDLE until the next start is accepted or reset.
- rcon sequence for rounds 1..10: 01 02 04 08 10 20 40 80 1b 36.
- round saturates at NR and never wraps.

Optional Feature:
- Macro: CED_RETRY_EN.
- When defined:
  - On the first mismatch in a given stage occurrence, the FSM holds the same state for one extra cycle (st_we = 0, key_step suppressed, round/rcon unchanged) and re-compares.
  - If the re-compare matches, st_we = 1 and the sequence continues; fault stays 0.
  - A second consecutive mismatch follows the fault path above.
  - The retry budget is 1 per stage occurrence and resets on each stage advance.
  - Added output retry_cnt [7:0]: saturating count of retries this operation, cleared on start accept.
- When not defined: no retry; the first mismatch faults immediately; retry_cnt is absent.

Test Plan:
- Clean run: pulse start with stage_out == stage_chk always -> busy high for 40 cycles; done in the 41st cycle; fault = 0; st_we count = 40; key_step count = 10; round sequence 0,1..10; no stage=3 in round 10.
- rcon check: sample rcon at each key_step -> 01,02,04,08,10,20,40,80,1b,36.
- Fault in round 3 MC (stage_chk bit 0 flipped for one cycle), no macro -> st_we = 0 in that cycle; done next cycle + 1; fault = 1; fault_round = 3; fault_stage = 3.
- CED_RETRY_EN with a single-cycle flip at round 5 SB -> SB held 2 cycles; fault = 0; retry_cnt = 1; done in the 42nd cycle. Same test with a 2-cycle flip -> fault = 1; fault_round = 5; fault_stage = 1.
- Assert rst at round 6 SR -> all outputs at reset values immediately. A subsequent start completes a clean 41-cycle run.
- start held high throughout -> the second operation begins only after DONE → IDLE, with a new start accepted in IDLE. start pulses during busy are ignored.
